// File: rtl/pixel_scheduler.sv
// pixel_scheduler
// Walks a frame of H_RES x V_RES pixels in raster order. For each pixel it
// hands one job (pixel position plus complex coordinate c) to an external
// depth calculator, waits for the result, then offers the result on a
// valid/ready pixel stream.
//
// Coordinates are signed fixed-point values with FRAC fractional bits. They
// are stepped incrementally with 32-bit wrapping adds, so no multiplier is
// needed.
//
// Ports
//   sysclk, reset_n          clock; asynchronous active-low reset
//   frame_start              one-cycle request to render a frame (IDLE only)
//   re_min, im_max, step     left-edge real, top-edge imaginary, per-pixel step
//   calc_start               one-cycle job strobe to the calculator
//   calc_x, calc_y           pixel position of the current job
//   calc_re_c, calc_im_c     coordinate c of the current job
//   calc_done, calc_depth    calculator completion strobe and its result
//   m_valid, m_ready         pixel stream handshake
//   m_data                   pixel depth
//   m_user, m_last           first pixel of frame; last pixel of line
//   busy                     a frame is in progress
//
// state  | meaning
// IDLE   | no frame; waiting for frame_start
// ISSUE  | calc_start pulsed for the current pixel
// WAIT   | waiting for calc_done; depth captured when it arrives
// OUTPUT | pixel held on the stream until m_ready
module pixel_scheduler #(
  parameter int FRAC  = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic               sysclk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic signed [31:0] re_min,
  input  logic signed [31:0] im_max,
  input  logic signed [31:0] step,
  output logic               calc_start,
  output logic [9:0]         calc_x,
  output logic [8:0]         calc_y,
  output logic signed [31:0] calc_re_c,
  output logic signed [31:0] calc_im_c,
  input  logic               calc_done,
  input  logic [7:0]         calc_depth,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [7:0]         m_data,
  output logic               m_user,
  output logic               m_last,
  output logic               busy
);

  // FRAC only documents the coordinate format; the datapath is format-agnostic.
  if (FRAC > 31) begin : g_frac_out_of_range
  end

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [9:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic signed [31:0] re_q, re_d;
  logic signed [31:0] im_q, im_d;
  logic signed [31:0] re_min_q, re_min_d;
  logic signed [31:0] step_q, step_d;
  logic [7:0]         data_q, data_d;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      re_q     <= '0;
      im_q     <= '0;
      re_min_q <= '0;
      step_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      re_q     <= re_d;
      im_q     <= im_d;
      re_min_q <= re_min_d;
      step_q   <= step_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    re_d     = re_q;
    im_d     = im_q;
    re_min_d = re_min_q;
    step_d   = step_q;
    data_d   = data_q;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          // im_max needs no shadow copy: im_c is only ever stepped down.
          re_min_d = re_min;
          step_d   = step;
          x_d      = '0;
          y_d      = '0;
          re_d     = re_min;
          im_d     = im_max;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (calc_done) begin
          data_d  = calc_depth;
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          if (x_q != X_LAST) begin
            x_d     = x_q + 10'd1;
            re_d    = re_q + step_q;
            state_d = ISSUE;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + 9'd1;
            re_d    = re_min_q;
            im_d    = im_q - step_q;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Job fields come straight from the pixel registers, which only change on
  // the transfer that leads into the next ISSUE, so they hold for the job.
  assign calc_start = (state_q == ISSUE);
  assign calc_x     = x_q;
  assign calc_y     = y_q;
  assign calc_re_c  = re_q;
  assign calc_im_c  = im_q;

  assign m_valid = (state_q == OUTPUT);
  assign m_data  = data_q;
  assign m_user  = m_valid && (x_q == '0) && (y_q == '0);
  assign m_last  = m_valid && (x_q == X_LAST);
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_scheduler.sv
module tb_pixel_scheduler;
  localparam int H = 4;
  localparam int V = 3;
  localparam int N = H * V;

  logic               sysclk = 1'b0;
  logic               reset_n = 1'b0;
  logic               frame_start = 1'b0;
  logic signed [31:0] re_min = '0;
  logic signed [31:0] im_max = '0;
  logic signed [31:0] step = '0;
  logic               calc_start;
  logic [9:0]         calc_x;
  logic [8:0]         calc_y;
  logic signed [31:0] calc_re_c;
  logic signed [31:0] calc_im_c;
  logic               calc_done = 1'b0;
  logic [7:0]         calc_depth = '0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [7:0]         m_data;
  logic               m_user;
  logic               m_last;
  logic               busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 sysclk = ~sysclk;

  pixel_scheduler #(.FRAC(16), .H_RES(H), .V_RES(V)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .frame_start(frame_start),
    .re_min(re_min), .im_max(im_max), .step(step),
    .calc_start(calc_start), .calc_x(calc_x), .calc_y(calc_y),
    .calc_re_c(calc_re_c), .calc_im_c(calc_im_c),
    .calc_done(calc_done), .calc_depth(calc_depth),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_user(m_user), .m_last(m_last), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Depth calculator: returns x+4y three cycles after the job strobe.
  initial begin
    int dx, dy;
    forever begin
      @(negedge sysclk);
      if (calc_start === 1'b1) begin
        dx = int'(calc_x);
        dy = int'(calc_y);
        repeat (3) @(negedge sysclk);
        calc_depth = 8'(dx + 4 * dy);
        calc_done  = 1'b1;
        @(negedge sysclk);
        calc_done  = 1'b0;
      end
    end
  end

  // Frame model: pixel k of a frame sits at (k%H, k/H) with
  // c = (re_min + x*step, im_max - y*step) and depth x+4y.
  logic signed [31:0] m_re_min, m_im_max, m_step;
  logic signed [31:0] e_re, e_im;
  int   ki, ko, kx, ky;
  bit   active, hold;
  logic [9:0] h_word;

  initial begin
    m_re_min = '0; m_im_max = '0; m_step = '0;
    ki = 0; ko = 0; active = 0; hold = 0; h_word = '0;
  end

  always @(negedge sysclk) begin
    if (!reset_n) begin
      check("reset_ctl", {calc_start, m_valid, m_user, m_last, busy, m_data, calc_x, calc_y}, 32'd0);
      check("reset_re", calc_re_c, 32'd0);
      check("reset_im", calc_im_c, 32'd0);
      ki = 0; ko = 0; active = 0; hold = 0;
    end else begin
      check("busy", {31'd0, busy}, {31'd0, active});
      if (hold) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {22'd0, m_user, m_last, m_data}, {22'd0, h_word});
      end
      hold = 0;
      if (calc_start) begin
        kx = ki % H;
        ky = ki / H;
        e_re = m_re_min + kx * m_step;
        e_im = m_im_max - ky * m_step;
        check("issue_order", ki, ko);
        check("calc_x", {22'd0, calc_x}, kx);
        check("calc_y", {23'd0, calc_y}, ky);
        check("calc_re_c", calc_re_c, e_re);
        check("calc_im_c", calc_im_c, e_im);
        ki++;
      end
      if (m_valid) begin
        kx = ko % H;
        ky = ko / H;
        if (m_ready) begin
          check("m_data", {24'd0, m_data}, 32'((kx + 4 * ky) & 255));
          check("m_user", {31'd0, m_user}, {31'd0, (ko == 0)});
          check("m_last", {31'd0, m_last}, {31'd0, (kx == H - 1)});
          ko++;
          if (ko == N) active = 0;
        end else begin
          hold   = 1;
          h_word = {m_user, m_last, m_data};
        end
      end
      if (frame_start && !active) begin
        m_re_min = re_min;
        m_im_max = im_max;
        m_step   = step;
        ki = 0; ko = 0; active = 1;
      end
    end
  end

  task automatic start_frame(input logic [31:0] r, input logic [31:0] i, input logic [31:0] s);
    @(posedge sysclk); #1;
    re_min = r; im_max = i; step = s; frame_start = 1'b1;
    @(posedge sysclk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_issue(input int x, input int y, output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge sysclk); #1;
      if (calc_start && int'(calc_x) == x && int'(calc_y) == y) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_issue: no calc_start seen, expected pixel (%0d,%0d)", x, y);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge sysclk); #1;
      if (m_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_valid: m_valid never rose, expected 1");
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(posedge sysclk); #1;
      if (!busy) break;
    end
    check("frame_end_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit ok;
    reset_n = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 reset_n = 1'b1;

    // Frame 1: reference frame with a stall on pixel 2 and a stray frame_start.
    start_frame(32'hFFFE0000, 32'h00010000, 32'h00010000);
    wait_issue(2, 0, ok);
    if (ok) begin
      check("px2_re_lit", calc_re_c, 32'h00000000);
      check("px2_im_lit", calc_im_c, 32'h00010000);
    end
    m_ready = 1'b0;
    wait_valid(ok);
    if (ok) begin
      check("px2_depth_lit", {24'd0, m_data}, 32'd2);
      check("px2_last_lit", {31'd0, m_last}, 32'd0);
    end
    @(posedge sysclk); #1;
    frame_start = 1'b1; re_min = 32'h12345678; step = 32'h5;
    @(posedge sysclk); #1;
    frame_start = 1'b0;
    repeat (3) @(posedge sysclk);
    #1 m_ready = 1'b1;
    wait_issue(3, 2, ok);
    if (ok) begin
      check("px11_re_lit", calc_re_c, 32'h00010000);
      check("px11_im_lit", calc_im_c, 32'hFFFF0000);
    end
    wait_idle();

    // Frame 2: reset during WAIT of pixel 5, then a clean restart.
    start_frame(32'hFFFE0000, 32'h00010000, 32'h00010000);
    wait_issue(1, 1, ok);
    if (ok) begin
      check("px5_re_lit", calc_re_c, 32'hFFFF0000);
      check("px5_im_lit", calc_im_c, 32'h00000000);
    end
    @(posedge sysclk); #1;
    reset_n = 1'b0;
    #1 check("async_reset_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge sysclk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge sysclk);
    #1;
    check("post_reset_idle", {30'd0, busy, m_valid}, 32'd0);

    start_frame(32'hFFFE0000, 32'h00010000, 32'h00010000);
    wait_valid(ok);
    if (ok) check("restart_first_px", {22'd0, m_user, m_last, m_data}, {22'd0, 1'b1, 1'b0, 8'd0});
    wait_idle();

    // Frame 3: real-axis wrap.
    start_frame(32'h7FFF0000, 32'h00000000, 32'h00020000);
    wait_issue(1, 0, ok);
    if (ok) check("wrap_re_lit", calc_re_c, 32'h80010000);
    wait_idle();

    repeat (3) @(posedge sysclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 The block SHALL have parameter FRAC, default 16, meaning fractional bits of all signed Q-format coordinate values.
REQ-002 The block SHALL have parameter H_RES, default 640, meaning pixels per line (x range 0..H_RES-1, H_RES <= 1024).
REQ-003 The block SHALL have parameter V_RES, default 480, meaning lines per frame (y range 0..V_RES-1, V_RES <= 512).
REQ-004 The block SHALL have port sysclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port frame_start, input, 1, meaning a one-cycle request to render one frame.
REQ-007 The block SHALL have ports re_min, im_max and step, each input, 32, signed, meaning the left-edge real value, top-edge imaginary value and per-pixel increment.
REQ-008 The block SHALL have ports calc_start (output, 1), calc_x (output, 10), calc_y (output, 9), calc_re_c (output, 32) and calc_im_c (output, 32), meaning the job issued to the depth calculator.
REQ-009 The block SHALL have ports calc_done (input, 1) and calc_depth (input, 8), meaning the depth calculator's completion flag and its result.
REQ-010 The block SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, 8), m_user (output, 1) and m_last (output, 1), meaning the downstream pixel stream (depth, frame-first pixel, end-of-line).
REQ-011 The block SHALL have port busy, output, 1, meaning a frame is in progress.

Function
REQ-012 The block SHALL implement the states IDLE, ISSUE, WAIT and OUTPUT.
REQ-013 In IDLE, when frame_start=1, the block SHALL latch re_min, im_max and step, set x=0, y=0, re_c=re_min and im_c=im_max, and go to ISSUE.
REQ-014 In ISSUE, the block SHALL assert calc_start for exactly one cycle with calc_x/calc_y/calc_re_c/calc_im_c equal to the current pixel, then go to WAIT.
REQ-015 calc_x, calc_y, calc_re_c and calc_im_c SHALL remain stable from ISSUE until the next ISSUE.
REQ-016 In WAIT, the block SHALL sample calc_done only; when it is 1, the block SHALL register calc_depth into m_data and go to OUTPUT.
REQ-017 In OUTPUT, the block SHALL hold m_valid=1 and keep m_data, m_user and m_last stable until the cycle in which m_ready=1 (the transfer).
REQ-018 m_user SHALL be 1 only for pixel (0,0), and m_last SHALL be 1 only when x=H_RES-1.
REQ-019 On a transfer with x<H_RES-1, the block SHALL set x=x+1 and re_c=re_c+step, then go to ISSUE.
REQ-020 On a transfer with x=H_RES-1 and y<V_RES-1, the block SHALL set x=0, y=y+1, re_c=latched re_min and im_c=im_c-step, then go to ISSUE.
REQ-021 On a transfer with x=H_RES-1 and y=V_RES-1, the block SHALL go to IDLE.
REQ-022 All coordinate additions SHALL be 32-bit two's complement and wrap silently on overflow; no multiplier SHALL be used.
REQ-023 The block SHALL ignore frame_start while not in IDLE, and SHALL apply changes to re_min/im_max/step only at the next accepted frame_start.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 The minimum per-pixel cost SHALL be 1 (ISSUE) + 1 or more (WAIT) + 1 or more (OUTPUT) cycles, which guarantees that the next calc_start follows an observed calc_done by at least 2 cycles.
REQ-026 If m_ready is held at 1 throughout, the block SHALL transfer in the first OUTPUT cycle.

Reset
REQ-027 While reset_n=0, the block SHALL be in IDLE with calc_start=0, m_valid=0, m_user=0, m_last=0, busy=0, m_data=0, x=0, y=0, calc_re_c=0 and calc_im_c=0.
REQ-028 A reset mid-frame SHALL abandon the frame immediately; after release, the block SHALL require a new frame_start and SHALL discard any calc_done.

Verification
REQ-029 With H_RES=4, V_RES=3, re_min=0xFFFE0000, im_max=0x00010000, step=0x00010000 and a calculator model returning depth=x+4y after 3 cycles, the bench SHALL see 12 pixels with depths 0..11, m_user only on the first pixel, m_last on pixels 3, 7 and 11, and busy falling after the 12th.
REQ-030 In the same frame, the bench SHALL see calc_re_c of -2.0, -1.0, 0.0, 1.0 on every line, and calc_im_c of 1.0, 0.0, -1.0 per line.
REQ-031 With m_ready=0 for 5 cycles on pixel 2, the bench SHALL see m_valid, m_data and m_last stable for all 5 cycles and no calc_start until the transfer.
REQ-032 A frame_start pulse mid-frame SHALL have no effect on the pixel count or coordinates.
REQ-033 With reset_n pulled low during WAIT of pixel 5, the bench SHALL see all outputs at reset values; a later frame_start SHALL restart from pixel (0,0) with m_user=1.
REQ-034 With re_min=0x7FFF0000 and step=0x00020000, the bench SHALL see the second pixel's calc_re_c equal to 0x80010000 (wrap).
